instr_encoder: RTL and testbench
================================

# instr_encoder

Streaming MIPS instruction encoder: the inverse of the `control` decoder. Accepts symbolic instruction requests (operation class plus register/immediate fields) over a valid/ready handshake, produces 32-bit machine words in the exact opcode/funct encodings the decoder consumes, and writes them sequentially into instruction memory. Used to load test programs into the processor's instruction memory, and as a stimulus source for decoder and CPU benches.

## Interface
- `ADDR_W`, 10: instruction-memory word-address width.
- `BASE_ADDR`, 0: first word address written after reset.
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `in_valid` input 1: request valid.
- `in_ready` output 1: request accepted when `in_valid && in_ready` at a rising edge.
- `op` input 4: operation class (encoding in package).
- `rs`, `rt`, `rd` input 5 each: register fields.
- `imm` input 26: `[15:0]` immediate for I-type; `[25:0]` target for J-type.
- `mem_we` output 1: instruction-memory write strobe.
- `mem_addr` output `ADDR_W`: word address.
- `mem_wdata` output 32: encoded instruction.
- `word_count` output `ADDR_W+1`: number of words written since reset.
- `full` output 1: sticky; the last address has been written.
- `err` output 2: sticky. `[0]` = illegal op seen; `[1]` = delay slot lost.

## Operation
- Op classes:
  - 0 NOP
  - 1 ADD
  - 2 SUB
  - 3 SLT
  - 4 JR
  - 5 SYSCALL
  - 6 LW
  - 7 SW
  - 8 BNE
  - 9 XORI
  - 10 J
  - 11 JAL
  - 12–15 illegal
- R-type words are `{000000, rs, rt, rd, 00000, funct}`. Funct values: ADD 100000, SUB 100010, SLT 101010, JR 001000 (`rt`, `rd` forced 0), SYSCALL 001100 (all other fields 0). NOP is 0x00000000.
- I-type words are `{opcode, rs, rt, imm[15:0]}`. Opcodes: LW 100011, SW 101011, BNE 000101, XORI 001110. `imm[25:16]` is ignored.
- J-type words are `{opcode, imm[25:0]}`. Opcodes: J 000010, JAL 000011.
- Write pointer `ptr` (`ADDR_W` bits) starts at `BASE_ADDR`. Each write uses `mem_addr = ptr`, then `ptr` and `word_count` increment by 1.
- Illegal op: the request is accepted and `err[0]` sets. No write occurs; `ptr` and `word_count` are unchanged.
- FSM states:
  - RST: entered on reset. Moves to RUN on the first edge after reset deasserts.
  - RUN: `in_ready=1`. Moves to SLOT after accepting a branch-class op (J, JR, JAL, BNE), only when the macro is defined. Moves to FULL when a write targets address 2^`ADDR_W`−1.
  - SLOT: `in_ready=0`. Writes NOP at `ptr`, then returns to RUN, or goes to FULL if that NOP occupied the last address.
  - FULL: `in_ready=0`, no writes. Left only by reset; the pointer never wraps.
- Branch written at the last address with the macro defined: enter FULL, drop the NOP, set `err[1]`.

## Timing
- Reset values: `in_ready=0`, `mem_we=0`, `mem_addr=0`, `mem_wdata=0`, `word_count=0`, `full=0`, `err=0`, `ptr=BASE_ADDR`. These hold while `reset` is high.
- `in_ready`, `mem_*`, `full` and `err` are all registered outputs.
- Latency: a request accepted at edge N appears as `mem_we=1` with `mem_addr`/`mem_wdata` valid during the cycle after edge N, and is captured by memory at edge N+1.
- `mem_we` is high for exactly one cycle per word.
- Throughput: one word per cycle in RUN, with no bubbles for back-to-back requests.
- SLOT costs exactly one cycle with `in_ready` low.
- `full` rises in the same cycle as `mem_we` for the last address, and `in_ready` falls in that same cycle.
- Reset mid-stream: everything returns to reset values immediately (asynchronously), and any pending SLOT NOP is discarded.

## Configuration
- `INSTR_ENCODER_DELAY_SLOT_EN` defined: every branch-class word is followed automatically by a NOP word through SLOT, and `err[1]` is live.
- Not defined: the SLOT state is not compiled, branches are written like any other op, and `err[1]` is tied to 0.

## Structure
- Shared package `mips_pkg` holds:
  - the op-class enum;
  - the opcode constants (LW, SW, J, JAL, BNE, XORI, R-type);
  - the funct constants (ADD, SUB, SLT, JR, SYSCALL);
  - the NOP word.
- The `control` decoder imports the same constants.
- One combinational sub-module, `instr_pack`, maps `op`/`rs`/`rt`/`rd`/`imm` to a word plus an illegal flag. The FSM, pointer and registers live in `instr_encoder`.

## Test plan
- ADD rs=1 rt=2 rd=3 after reset → `mem_we` pulse, `mem_addr=0`, `mem_wdata=0x00221820`, `word_count=1`.
- LW rs=29 rt=8 imm=0x0004, then SW rs=29 rt=8 imm=0x0004 back-to-back → 0x8FA80004 at address 0 and 0xAFA80004 at address 1, on consecutive cycles.
- BNE rs=4 rt=5 imm=0xFFFE with the macro defined → 0x1485FFFE at address n, then 0x00000000 at n+1, with `in_ready` low for one cycle. Without the macro → only 0x1485FFFE is written.
- J imm=0x0100000 and JAL imm=0x0000040 → words 0x08100000 and 0x0C000040.
- `op=13` → no write, `err=01`, `word_count` unchanged; the next valid op is written at the unchanged address.
- `ADDR_W=2`: four ADDs → `full` rises with the write to address 3 and `in_ready` goes low; a fifth request is never accepted. With the macro defined, a J as the 4th word → `err[1]=1` and no NOP is written. Asserting `reset` mid-run → all outputs return to their reset values.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS encoding constants: op classes, opcodes, funct codes, NOP word.
// Also imported by the control decoder so both sides agree on encodings.
package mips_pkg;

    // Symbolic operation classes accepted by the encoder; 12..15 are illegal.
    typedef enum logic [3:0] {
        OP_NOP     = 4'd0,
        OP_ADD     = 4'd1,
        OP_SUB     = 4'd2,
        OP_SLT     = 4'd3,
        OP_JR      = 4'd4,
        OP_SYSCALL = 4'd5,
        OP_LW      = 4'd6,
        OP_SW      = 4'd7,
        OP_BNE     = 4'd8,
        OP_XORI    = 4'd9,
        OP_J       = 4'd10,
        OP_JAL     = 4'd11
    } op_e;

    // Encoder FSM states.
    typedef enum logic [1:0] {
        ST_RST  = 2'd0,
        ST_RUN  = 2'd1,
        ST_SLOT = 2'd2,
        ST_FULL = 2'd3
    } enc_state_e;

    localparam logic [5:0] OPC_RTYPE = 6'b000000;
    localparam logic [5:0] OPC_LW    = 6'b100011;
    localparam logic [5:0] OPC_SW    = 6'b101011;
    localparam logic [5:0] OPC_BNE   = 6'b000101;
    localparam logic [5:0] OPC_XORI  = 6'b001110;
    localparam logic [5:0] OPC_J     = 6'b000010;
    localparam logic [5:0] OPC_JAL   = 6'b000011;

    localparam logic [5:0] FUNCT_ADD     = 6'b100000;
    localparam logic [5:0] FUNCT_SUB     = 6'b100010;
    localparam logic [5:0] FUNCT_SLT     = 6'b101010;
    localparam logic [5:0] FUNCT_JR      = 6'b001000;
    localparam logic [5:0] FUNCT_SYSCALL = 6'b001100;

    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    // Branch-class ops are the ones that own a delay slot.
    function automatic logic is_branch_op(input logic [3:0] op);
        return (op == OP_J) || (op == OP_JR) || (op == OP_JAL) || (op == OP_BNE);
    endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational packer: op class plus fields -> 32-bit MIPS word and illegal flag.
module instr_pack
    import mips_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [25:0] imm,
    output logic [31:0] word,
    output logic        illegal
);

    // Select the R/I/J layout per op class; unknown classes flag illegal and emit NOP.
    always_comb begin
        word    = NOP_WORD;
        illegal = 1'b0;
        case (op)
            OP_NOP:     word = NOP_WORD;
            OP_ADD:     word = {OPC_RTYPE, rs, rt, rd, 5'b00000, FUNCT_ADD};
            OP_SUB:     word = {OPC_RTYPE, rs, rt, rd, 5'b00000, FUNCT_SUB};
            OP_SLT:     word = {OPC_RTYPE, rs, rt, rd, 5'b00000, FUNCT_SLT};
            OP_JR:      word = {OPC_RTYPE, rs, 5'b00000, 5'b00000, 5'b00000, FUNCT_JR};
            OP_SYSCALL: word = {OPC_RTYPE, 20'h00000, FUNCT_SYSCALL};
            OP_LW:      word = {OPC_LW,   rs, rt, imm[15:0]};
            OP_SW:      word = {OPC_SW,   rs, rt, imm[15:0]};
            OP_BNE:     word = {OPC_BNE,  rs, rt, imm[15:0]};
            OP_XORI:    word = {OPC_XORI, rs, rt, imm[15:0]};
            OP_J:       word = {OPC_J,   imm};
            OP_JAL:     word = {OPC_JAL, imm};
            default:    illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Streaming instruction encoder: accepts symbolic requests over valid/ready and
// writes encoded words sequentially into instruction memory.
// Optional feature macro: INSTR_ENCODER_DELAY_SLOT_EN (auto NOP after branches).
//
// Handshake: a request transfers on a rising edge where in_valid && in_ready;
// in_ready is a registered output that is high only in RUN, and the requester
// must hold its fields stable while in_valid is high and in_ready is low.
module instr_encoder
    import mips_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int BASE_ADDR = 0
)
(
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        op,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [4:0]        rd,
    input  logic [25:0]       imm,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [ADDR_W:0]   word_count,
    output logic              full,
    output logic [1:0]        err,
    output logic [1:0]        dbg_state
);

    localparam logic [ADDR_W-1:0] BASE_PTR = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] LAST_PTR = '1;

    enc_state_e        state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              in_ready_q, in_ready_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic [ADDR_W:0]   word_count_q, word_count_d;
    logic              full_q, full_d;
    logic [1:0]        err_q, err_d;

    logic [31:0]       packed_word;
    logic              packed_illegal;
    logic              accept;
    logic              at_last;

    instr_pack u_pack (
        .op      (op),
        .rs      (rs),
        .rt      (rt),
        .rd      (rd),
        .imm     (imm),
        .word    (packed_word),
        .illegal (packed_illegal)
    );

    assign accept  = in_valid && in_ready_q;
    assign at_last = (ptr_q == LAST_PTR);

    // Next-state, write strobe, pointer and sticky flag logic.
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        word_count_d = word_count_q;
        full_d       = full_q;
        err_d        = err_q;
        case (state_q)
            ST_RST: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (accept) begin
                    if (packed_illegal) begin
                        err_d[0] = 1'b1;
                    end else begin
                        mem_we_d     = 1'b1;
                        mem_addr_d   = ptr_q;
                        mem_wdata_d  = packed_word;
                        word_count_d = word_count_q + (ADDR_W+1)'(1);
                        // Pointer saturates at the last address rather than wrapping.
                        ptr_d        = at_last ? ptr_q : ptr_q + ADDR_W'(1);
                        if (at_last) begin
                            state_d = ST_FULL;
                            full_d  = 1'b1;
`ifdef INSTR_ENCODER_DELAY_SLOT_EN
                            // No room for the delay-slot NOP.
                            if (is_branch_op(op)) begin
                                err_d[1] = 1'b1;
                            end
`endif
                        end
`ifdef INSTR_ENCODER_DELAY_SLOT_EN
                        else if (is_branch_op(op)) begin
                            state_d = ST_SLOT;
                        end
`endif
                    end
                end
            end
`ifdef INSTR_ENCODER_DELAY_SLOT_EN
            ST_SLOT: begin
                mem_we_d     = 1'b1;
                mem_addr_d   = ptr_q;
                mem_wdata_d  = NOP_WORD;
                word_count_d = word_count_q + (ADDR_W+1)'(1);
                ptr_d        = at_last ? ptr_q : ptr_q + ADDR_W'(1);
                if (at_last) begin
                    state_d = ST_FULL;
                    full_d  = 1'b1;
                end else begin
                    state_d = ST_RUN;
                end
            end
`endif
            ST_FULL: begin
                state_d = ST_FULL;
            end
            default: begin
                state_d = ST_FULL;
            end
        endcase
        in_ready_d = (state_d == ST_RUN);
    end

    // State and output registers; reset clears everything asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_RST;
            ptr_q        <= BASE_PTR;
            in_ready_q   <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            word_count_q <= '0;
            full_q       <= 1'b0;
            err_q        <= 2'b00;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            in_ready_q   <= in_ready_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            word_count_q <= word_count_d;
            full_q       <= full_d;
            err_q        <= err_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign word_count = word_count_q;
    assign full       = full_q;
    assign err        = err_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder with a 4-word memory (ADDR_W=2).
// Expectations follow INSTR_ENCODER_DELAY_SLOT_EN when it is defined.
module tb_instr_encoder;
    import mips_pkg::*;

    localparam int AW = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    op;
    logic [4:0]    rs, rt, rd;
    logic [25:0]   imm;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [AW:0]   word_count;
    logic          full;
    logic [1:0]    err;
    logic [1:0]    dbg_state;

    int checks   = 0;
    int failures = 0;

    instr_encoder #(.ADDR_W(AW), .BASE_ADDR(0)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .op         (op),
        .rs         (rs),
        .rt         (rt),
        .rd         (rd),
        .imm        (imm),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .word_count (word_count),
        .full       (full),
        .err        (err),
        .dbg_state  (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] o, input logic [4:0] s, input logic [4:0] t,
                         input logic [4:0] d, input logic [25:0] i);
        in_valid = 1'b1;
        op = o; rs = s; rt = t; rd = d; imm = i;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        op = 4'd0; rs = 5'd0; rt = 5'd0; rd = 5'd0; imm = 26'd0;
    endtask

    task automatic expect_write(input string tag, input logic [31:0] addr, input logic [31:0] word);
        check({tag, "_we"},   mem_we,    1);
        check({tag, "_addr"}, mem_addr,  addr);
        check({tag, "_data"}, mem_wdata, word);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_ready"}, in_ready,   0);
        check({tag, "_we"},    mem_we,     0);
        check({tag, "_addr"},  mem_addr,   0);
        check({tag, "_data"},  mem_wdata,  0);
        check({tag, "_wc"},    word_count, 0);
        check({tag, "_full"},  full,       0);
        check({tag, "_err"},   err,        0);
    endtask

    task automatic do_reset(input string tag);
        idle();
        reset = 1'b1;
        tick();
        tick();
        check_reset_vals(tag);
        @(negedge clk);
        reset = 1'b0;
        tick();
        check({tag, "_ready_after"}, in_ready, 1);
    endtask

    initial begin
        reset = 1'b1;
        idle();

        // A: R-type words, JR landing on the last address.
        do_reset("rst_a");
        drive(OP_ADD, 5'd1, 5'd2, 5'd3, 26'd0);
        tick();
        expect_write("add", 0, 32'h0022_1820);
        check("add_wc", word_count, 1);
        check("add_ready", in_ready, 1);
        drive(OP_SUB, 5'd1, 5'd2, 5'd3, 26'd0);
        tick();
        expect_write("sub", 1, 32'h0022_1822);
        drive(OP_SYSCALL, 5'd7, 5'd8, 5'd9, 26'h3FF_FFFF);
        tick();
        expect_write("syscall", 2, 32'h0000_000C);
        drive(OP_JR, 5'd31, 5'd2, 5'd3, 26'h000_0123);
        tick();
        expect_write("jr", 3, 32'h03E0_0008);
        check("jr_full", full, 1);
        check("jr_ready", in_ready, 0);
        check("jr_wc", word_count, 4);
`ifdef INSTR_ENCODER_DELAY_SLOT_EN
        check("jr_err", err, 2'b10);
`else
        check("jr_err", err, 2'b00);
`endif
        idle();
        tick();
        check("a_tail_we", mem_we, 0);
        check("a_tail_wc", word_count, 4);

        // B: back-to-back I-type, illegal op, fill to full, blocked request.
        do_reset("rst_b");
        drive(OP_LW, 5'd29, 5'd8, 5'd0, 26'h3FF_0004);
        tick();
        expect_write("lw", 0, 32'h8FA8_0004);
        drive(OP_SW, 5'd29, 5'd8, 5'd0, 26'h000_0004);
        tick();
        expect_write("sw", 1, 32'hAFA8_0004);
        drive(4'd13, 5'd1, 5'd2, 5'd3, 26'd5);
        tick();
        check("ill_we", mem_we, 0);
        check("ill_err", err, 2'b01);
        check("ill_wc", word_count, 2);
        check("ill_ready", in_ready, 1);
        drive(OP_SLT, 5'd1, 5'd2, 5'd3, 26'd0);
        tick();
        expect_write("slt", 2, 32'h0022_182A);
        check("slt_err", err, 2'b01);
        drive(OP_XORI, 5'd1, 5'd2, 5'd0, 26'h000_1234);
        tick();
        expect_write("xori", 3, 32'h3822_1234);
        check("xori_full", full, 1);
        check("xori_ready", in_ready, 0);
        check("xori_wc", word_count, 4);
        drive(OP_ADD, 5'd1, 5'd1, 5'd1, 26'd0);
        tick();
        tick();
        check("blocked_we", mem_we, 0);
        check("blocked_wc", word_count, 4);
        check("blocked_addr", mem_addr, 3);
        check("blocked_err", err, 2'b01);

        // C: BNE, J, JAL.
        do_reset("rst_c");
        drive(OP_BNE, 5'd4, 5'd5, 5'd0, 26'h000_FFFE);
        tick();
        expect_write("bne", 0, 32'h1485_FFFE);
`ifdef INSTR_ENCODER_DELAY_SLOT_EN
        check("bne_ready", in_ready, 0);
        drive(OP_J, 5'd0, 5'd0, 5'd0, 26'h010_0000);
        tick();
        expect_write("slot_nop", 1, 32'h0000_0000);
        check("slot_ready", in_ready, 1);
        check("slot_wc", word_count, 2);
        tick();
        expect_write("j", 2, 32'h0810_0000);
        check("j_ready", in_ready, 0);
        idle();
        tick();
        expect_write("j_nop", 3, 32'h0000_0000);
        check("j_nop_full", full, 1);
        check("j_nop_wc", word_count, 4);
        check("j_nop_err", err, 2'b00);
`else
        check("bne_ready", in_ready, 1);
        drive(OP_J, 5'd0, 5'd0, 5'd0, 26'h010_0000);
        tick();
        expect_write("j", 1, 32'h0810_0000);
        drive(OP_JAL, 5'd0, 5'd0, 5'd0, 26'h000_0040);
        tick();
        expect_write("jal", 2, 32'h0C00_0040);
        idle();
        tick();
        check("c_tail_we", mem_we, 0);
        check("c_tail_wc", word_count, 3);
        check("c_tail_full", full, 0);
`endif

        // D: branch written at the last address.
        do_reset("rst_d");
        for (int i = 0; i < 3; i++) begin
            drive(OP_ADD, 5'd1, 5'd2, 5'd3, 26'd0);
            tick();
        end
        check("d_pre_wc", word_count, 3);
        drive(OP_JAL, 5'd0, 5'd0, 5'd0, 26'h000_0040);
        tick();
        expect_write("jal_last", 3, 32'h0C00_0040);
        check("jal_last_full", full, 1);
        check("jal_last_ready", in_ready, 0);
`ifdef INSTR_ENCODER_DELAY_SLOT_EN
        check("jal_last_err", err, 2'b10);
`else
        check("jal_last_err", err, 2'b00);
`endif
        idle();
        tick();
        check("d_tail_we", mem_we, 0);
        check("d_tail_wc", word_count, 4);

        // E: NOP op, then asynchronous reset mid-stream.
        do_reset("rst_e");
        drive(OP_NOP, 5'd5, 5'd6, 5'd7, 26'h3FF_FFFF);
        tick();
        expect_write("nop", 0, 32'h0000_0000);
        check("nop_wc", word_count, 1);
        drive(OP_ADD, 5'd1, 5'd2, 5'd3, 26'd0);
        tick();
        expect_write("add2", 1, 32'h0022_1820);
        #2;
        reset = 1'b1;
        #1;
        check_reset_vals("async_rst");
        do_reset("rst_f");
        drive(OP_ADD, 5'd1, 5'd2, 5'd3, 26'd0);
        tick();
        expect_write("post_rst", 0, 32'h0022_1820);
        check("post_rst_wc", word_count, 1);
        idle();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
